// File: rtl/mux16_pkg.sv
// mux16_pkg: shared constants, FSM state type and select decode for the 16-way arbiter
package mux16_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        REL   = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux16to1_41.sv
// mux16to1_41: combinational 16:1 single-bit multiplexer
module mux16to1_41 (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out
);

    assign out = in[sel];

endmodule

// File: rtl/rr_pick16.sv
// rr_pick16: combinational round-robin pick, first set request at or after ptr (wrapping)
module rr_pick16
    import mux16_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             valid
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    // rotate so that bit 0 of rot is requester ptr, then take the lowest set bit
    always_comb begin
        rot = '0;
        off = '0;
        for (int i = 0; i < N_REQ; i++)
            rot[i] = req[ptr + SEL_W'(i)];
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) off = SEL_W'(i);
    end

    assign idx   = ptr + off;
    assign valid = |req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: hold-limited round-robin owner of a shared 16:1 mux select
module mux16_rr_arbiter
    import mux16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             dout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic [SEL_W-1:0] ptr, ptr_nx, sel_nx, pick_idx;
    logic [7:0]       hold_cnt, hold_nx;
    logic             pick_valid, mux_out;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    mux16to1_41 u_mux (
        .in  (din),
        .sel (sel),
        .out (mux_out)
    );

    // state, pointer, select and hold counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            sel      <= sel_nx;
            hold_cnt <= hold_nx;
        end
    end

    // arbitrate in IDLE, count and release in GRANT, single gap cycle in REL
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    sel_nx   = pick_idx;
                    hold_nx  = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                hold_nx = hold_cnt + 8'd1;
                if (!req[sel] || hold_cnt == HOLD_LAST) begin
                    ptr_nx   = sel + SEL_W'(1);
                    state_nx = REL;
                end
            end
            REL:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == GRANT);
    assign gnt  = busy ? onehot16(sel) : '0;
    assign dout = mux_out & busy;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed and randomized checks of two arbiters against a behavioural model
module tb_mux16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'hFFFF;
    logic [15:0] din = '0;

    logic [15:0] gnt_o[2];
    logic [3:0]  sel_o[2];
    logic        busy_o[2];
    logic        dout_o[2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux16_rr_arbiter #(.MAX_HOLD(8)) u0 (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_o[0]), .sel(sel_o[0]), .busy(busy_o[0]), .dout(dout_o[0])
    );

    mux16_rr_arbiter #(.MAX_HOLD(1)) u1 (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_o[1]), .sel(sel_o[1]), .busy(busy_o[1]), .dout(dout_o[1])
    );

    // model: who owns the mux, how many cycles it has had, whether the gap is running
    typedef struct {
        int owner;
        int held;
        bit gap;
        int ptr;
        int sel;
    } mdl_t;

    mdl_t md[2];

    function automatic int max_hold(int i);
        return (i == 0) ? 8 : 1;
    endfunction

    function automatic mdl_t reset_mdl();
        mdl_t m;
        m.owner = -1; m.held = 0; m.gap = 1'b0; m.ptr = 0; m.sel = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, logic [15:0] r, int maxh);
        mdl_t n = m;
        bit found = 1'b0;
        if (m.gap) n.gap = 1'b0;
        else if (m.owner >= 0) begin
            if (!r[m.owner] || m.held == maxh) begin
                n.ptr = (m.owner + 1) % 16;
                n.owner = -1;
                n.gap = 1'b1;
            end else n.held = m.held + 1;
        end else begin
            for (int k = 0; k < 16; k++)
                if (!found && r[(m.ptr + k) % 16]) begin
                    found = 1'b1;
                    n.owner = (m.ptr + k) % 16;
                    n.sel = n.owner;
                    n.held = 1;
                end
        end
        return n;
    endfunction

    function automatic int oh2i(logic [15:0] g);
        int r = 99;
        for (int i = 0; i < 16; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++)
            md[i] <= rst ? reset_mdl() : step(md[i], req, max_hold(i));
    end

    // compare both DUTs against the model on every falling edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("gnt[%0d]", i), gnt_o[i], md[i].owner >= 0 ? 16'(1) << md[i].owner : 16'h0);
            chk($sformatf("busy[%0d]", i), busy_o[i], md[i].owner >= 0);
            chk($sformatf("sel[%0d]", i), sel_o[i], md[i].sel);
            chk($sformatf("dout[%0d]", i), dout_o[i], md[i].owner >= 0 ? din[md[i].sel] : 1'b0);
        end
        chk("ptr[0]", u0.ptr, md[0].ptr);
        chk("ptr[1]", u1.ptr, md[1].ptr);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int cap[3];
    logic [15:0] prev;
    int nc;

    initial begin
        #1;
        chk("rst_gnt", gnt_o[0], 16'h0);
        chk("rst_busy", busy_o[0], 1'b0);
        chk("rst_dout", dout_o[0], 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("first_gnt", gnt_o[0], 16'h0001);
        chk("first_sel", sel_o[0], 4'd0);
        for (int c = 1; c < 170; c++) begin
            tick();
            @(negedge clk);
            chk("sweep_gnt", gnt_o[0], (c % 10) < 8 ? 16'(1) << ((c / 10) % 16) : 16'h0);
        end

        do_reset();
        din = 16'b0101110010011010;
        req = 16'h0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("early_gnt", gnt_o[0], 16'h0010);
            chk("early_sel", sel_o[0], 4'd4);
            chk("early_dout", dout_o[0], 1'b1);
        end
        req = '0;
        tick();
        @(negedge clk);
        chk("early_rel", gnt_o[0], 16'h0);
        chk("early_ptr", u0.ptr, 4'd5);

        req = 16'h8009;
        prev = '0;
        nc = 0;
        cap = '{99, 99, 99};
        for (int c = 0; c < 60 && nc < 3; c++) begin
            tick();
            @(negedge clk);
            if (gnt_o[0] != 0 && prev == 0) begin
                cap[nc] = oh2i(gnt_o[0]);
                nc++;
            end
            prev = gnt_o[0];
        end
        chk("skip_0", cap[0], 15);
        chk("skip_1", cap[1], 0);
        chk("skip_2", cap[2], 3);

        do_reset();
        req = 16'h0004;
        for (int c = 0; c < 8; c++) tick();
        @(negedge clk);
        chk("both_gnt", gnt_o[0], 16'h0004);
        chk("both_cnt", u0.hold_cnt, 8'd7);
        req = '0;
        tick();
        @(negedge clk);
        chk("both_rel", gnt_o[0], 16'h0);
        req = 16'h0004;
        tick();
        @(negedge clk);
        chk("both_idle", gnt_o[0], 16'h0);
        chk("both_ptr", u0.ptr, 4'd3);
        tick();
        @(negedge clk);
        chk("both_regnt", gnt_o[0], 16'h0004);

        do_reset();
        req = 16'h0200;
        tick();
        @(negedge clk);
        chk("mid_gnt", gnt_o[0], 16'h0200);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", gnt_o[0], 16'h0);
        chk("mid_rst_busy", busy_o[0], 1'b0);
        chk("mid_rst_ptr", u0.ptr, 4'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_regnt", gnt_o[0], 16'h0200);

        for (int c = 0; c < 4000; c++) begin
            tick();
            din = 16'($urandom);
            if (rst) rst = 1'b0;
            if ($urandom_range(3) == 0)
                case ($urandom_range(3))
                    0: req = '0;
                    1: req = 16'(1) << $urandom_range(15);
                    2: req = 16'($urandom & $urandom);
                    default: req = $urandom_range(1) ? 16'hFFFF : 16'($urandom);
                endcase
            if ($urandom_range(399) == 0) begin
                #1;
                rst = 1'b1;
            end
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter that shares one 16:1 single-bit mux between 16 requesters. It grants one requester at a time, drives the mux select to that requester's index, and presents that requester's data bit on a registered-control output path. A grant is bounded by a hold limit, so no requester can starve the others. It sits directly in front of `mux16to1_41`, which it instantiates, and owns its `sel` input.

## Interface
- `MAX_HOLD`, 8: maximum consecutive cycles one grant may last; legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 16: per-requester request level; bit i = requester i.
- `din` input 16: per-requester data bit; bit i belongs to requester i.
- `gnt` output 16: one-hot grant, or all-zero when no grant is active.
- `sel` output 4: current mux select (index of the granted requester).
- `busy` output 1: high while a grant is active (`gnt` != 0).
- `dout` output 1: `din[sel]` when `busy`, else 0.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: one requester owns the mux.
  - REL: one-cycle release gap, then return to IDLE.
- Registers:
  - `ptr` (4 bit): highest-priority index for the next arbitration.
  - `sel` (4 bit).
  - `hold_cnt` (8 bit).
  - state.
- IDLE:
  - If `req` != 0, pick the first set bit scanning `ptr`, `ptr+1`, … , wrapping modulo 16.
  - Load `sel` with the winner, clear `hold_cnt`, go to GRANT.
  - If `req` == 0, stay in IDLE.
- GRANT:
  - `gnt` = one-hot(`sel`), `busy` = 1.
  - Each cycle in GRANT, increment `hold_cnt`.
  - Leave GRANT when either `req[sel]` == 0 or `hold_cnt` == `MAX_HOLD`-1. Both conditions together count as a single release.
  - On leaving: `ptr` ← `sel`+1 (4-bit wrap, so 15→0); next state REL.
- REL: `gnt` = 0, `busy` = 0; next state IDLE unconditionally.
- Only `req[sel]` matters in GRANT. Other requests are ignored until the next arbitration.
- `dout` comes from the combinational output of `mux16to1_41` (driven by `din`, `sel`), ANDed with `busy`.

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0, `sel` = 0, `hold_cnt` = 0.
  - `gnt` = 0, `busy` = 0, `dout` = 0.
- Reset asserted mid-grant drops `gnt` and `busy` immediately (asynchronous), with no release gap.
- Grant latency: a `req` bit sampled high at edge k in IDLE gives `gnt` high after edge k, visible in cycle k+1.
- Grant duration: at most `MAX_HOLD` cycles. With `MAX_HOLD` = 1, every grant is exactly 1 cycle.
- Requester drops `req` in cycle c while granted: `gnt` falls after the edge ending cycle c. The grant lasts one cycle past the drop.
- Back-to-back grants are separated by exactly 2 non-granted cycles (REL + IDLE). Worst-case wait for requester i with all 16 requesting is 15 × (`MAX_HOLD` + 2) cycles.
- `gnt`, `sel`, `busy` are registered (driven from state/`sel` flops only).
- `dout` is combinational from `din`, valid in the same cycle as `din`.

## Structure
- Shared package `mux16_pkg`:
  - `N_REQ` = 16, `SEL_W` = 4.
  - FSM state enum {IDLE, GRANT, REL}.
  - One-hot decode function (4→16).
- Sub-modules:
  - One instance of the existing `mux16to1_41` (ports `in`, `sel`, `out`) as the datapath.
  - Round-robin priority pick (rotate by `ptr`, find first set, rotate back) as sub-module `rr_pick16`, purely combinational: `req`[16], `ptr`[4] → `idx`[4], `valid`.

## Test plan
- Reset:
  - `rst` = 1 with `req` = 16'hFFFF.
  - Required: `gnt` = 0, `busy` = 0, `dout` = 0.
  - After release, first grant goes to `sel` = 0 exactly one cycle after IDLE samples.
- Round-robin full sweep:
  - `req` = 16'hFFFF held, `MAX_HOLD` = 8.
  - Required: grants in order 0, 1, … , 15, 0 (wrap); each grant 8 cycles, 2-cycle gaps; period 160 cycles.
- Early release and data:
  - `din` = 16'b0101110010011010, `req` = 16'h0010 for 3 cycles, then 0.
  - Required: `sel` = 4, `dout` = 1 while granted; `gnt` = 16'h0010 for 3 cycles; `ptr` = 5 afterwards.
- Pointer skip:
  - After a grant to 4, drive `req` = 16'h8009.
  - Required: next grant order 15, 0, 3.
- Simultaneous timeout and drop:
  - Requester 2 drops `req` in the same cycle `hold_cnt` = `MAX_HOLD`-1.
  - Required: a single release, one REL cycle, `ptr` = 3.
- Reset mid-grant:
  - Assert `rst` during GRANT on requester 9.
  - Required: `gnt` = 0 immediately, `ptr` = 0; after release with `req` = 16'h0200, grant to 9 again.
